// File: rtl/vga_text_ctrl.sv
// 640x480@60 VGA timing and character-grid walker feeding the ASCII pixel renderer.
// Stage 0 owns the counters and text_addr; stage 1 outputs line up with text_rdata.
module vga_text_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CHAR_W       = 9,
    parameter int CHAR_H       = 16,
    parameter int COLS         = 70,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        cursor_en,
    input  logic [6:0]  cur_col,
    input  logic [4:0]  cur_row,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_rdata,
    output logic [7:0]  char,
    output logic [3:0]  h_font,
    output logic [3:0]  v_font,
    output logic        c_valid,
    output logic        cursor,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  TEXT_W      = 10'(COLS * CHAR_W);
    localparam logic [9:0]  TEXT_H      = 10'(ROWS * CHAR_H);
    localparam logic [9:0]  TEXT_W_LAST = 10'(COLS * CHAR_W - 1);
    localparam logic [9:0]  TEXT_H_LAST = 10'(ROWS * CHAR_H - 1);
    localparam logic [9:0]  HS_FIRST    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [3:0]  FONT_W_LAST = 4'(CHAR_W - 1);
    localparam logic [3:0]  FONT_H_LAST = 4'(CHAR_H - 1);
    localparam logic [11:0] COLS_STEP   = 12'(COLS);
    localparam logic [5:0]  BLINK_LAST  = 6'(BLINK_FRAMES - 1);

    // stage 0
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [3:0]  hf_q, hf_d;
    logic [3:0]  vf_q, vf_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] row_base_q, row_base_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic        blink_on_q, blink_on_d;
    // stage 1 and sync delay line
    logic [3:0]  h_font_q, h_font_d;
    logic [3:0]  v_font_q, v_font_d;
    logic        c_valid_q, c_valid_d;
    logic        cursor_q, cursor_d;
    logic [1:0]  hs_pipe_q, hs_pipe_d;
    logic [1:0]  vs_pipe_q, vs_pipe_d;

    logic line_end, frame_end, valid0, next_line_text, hs_raw, vs_raw;

    always_comb begin
        line_end       = (h_cnt_q == H_LAST);
        frame_end      = line_end && (v_cnt_q == V_LAST);
        valid0         = (h_cnt_q < TEXT_W) && (v_cnt_q < TEXT_H);
        next_line_text = (v_cnt_q == V_LAST) || (v_cnt_q < TEXT_H_LAST);
        hs_raw         = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_raw         = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

        h_cnt_d     = line_end ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d     = v_cnt_q;
        hf_d        = hf_q;
        vf_d        = vf_q;
        col_d       = col_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;

        if (line_end) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        // The last text pixel does not advance, so text_addr holds the final cell outside the area.
        if (valid0 && (h_cnt_q != TEXT_W_LAST)) begin
            if (hf_q == FONT_W_LAST) begin
                hf_d  = 4'd0;
                col_d = col_q + 7'd1;
            end else begin
                hf_d = hf_q + 4'd1;
            end
        end
        if (line_end && next_line_text) begin
            hf_d  = 4'd0;
            col_d = 7'd0;
        end

        if (line_end && (v_cnt_q < TEXT_H_LAST)) begin
            if (vf_q == FONT_H_LAST) begin
                vf_d       = 4'd0;
                row_d      = row_q + 5'd1;
                row_base_d = row_base_q + COLS_STEP;
            end else begin
                vf_d = vf_q + 4'd1;
            end
        end

        // Counting frame wraps: the frame right after reset release is frame 0 of the first on phase.
        if (frame_end) begin
            vf_d       = 4'd0;
            row_d      = 5'd0;
            row_base_d = 12'd0;
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = 6'd0;
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end
        end

        h_font_d  = hf_q;
        v_font_d  = vf_q;
        c_valid_d = valid0;
        cursor_d  = cursor_en && blink_on_q && valid0 && (col_q == cur_col) && (row_q == cur_row);
        hs_pipe_d = {hs_pipe_q[0], hs_raw};
        vs_pipe_d = {vs_pipe_q[0], vs_raw};
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            hf_q        <= 4'd0;
            vf_q        <= 4'd0;
            col_q       <= 7'd0;
            row_q       <= 5'd0;
            row_base_q  <= 12'd0;
            frame_cnt_q <= 6'd0;
            blink_on_q  <= 1'b1;
            h_font_q    <= 4'd0;
            v_font_q    <= 4'd0;
            c_valid_q   <= 1'b0;
            cursor_q    <= 1'b0;
            hs_pipe_q   <= 2'b11;
            vs_pipe_q   <= 2'b11;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hf_q        <= hf_d;
            vf_q        <= vf_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
            h_font_q    <= h_font_d;
            v_font_q    <= v_font_d;
            c_valid_q   <= c_valid_d;
            cursor_q    <= cursor_d;
            hs_pipe_q   <= hs_pipe_d;
            vs_pipe_q   <= vs_pipe_d;
        end
    end

    assign text_addr   = row_base_q + {5'd0, col_q};
    assign char        = text_rdata;
    assign h_font      = h_font_q;
    assign v_font      = v_font_q;
    assign c_valid     = c_valid_q;
    assign cursor      = cursor_q;
    assign hsync       = hs_pipe_q[1];
    assign vsync       = vs_pipe_q[1];
    assign frame_start = rst && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl: a full-size instance for line/row addressing and hsync,
// and a shrunken-geometry instance so whole frames, vsync and blink fit in a short run.
module tb_vga_text_ctrl;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [3:0]  hf;
        logic [3:0]  vf;
        logic        cv;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;

    typedef struct {
        int ht, vt, cw, ch, cols, rows, hs_a, hs_b, vs_a, vs_b;
    } geo_t;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    // full-size instance
    logic        rst_f, cursor_en_f;
    logic [6:0]  cur_col_f;
    logic [4:0]  cur_row_f;
    logic [11:0] text_addr_f;
    logic [7:0]  text_rdata_f, char_f;
    logic [3:0]  h_font_f, v_font_f;
    logic        c_valid_f, cursor_f, hsync_f, vsync_f, frame_start_f;

    // small-geometry instance
    logic        rst_s, cursor_en_s;
    logic [6:0]  cur_col_s;
    logic [4:0]  cur_row_s;
    logic [11:0] text_addr_s;
    logic [7:0]  text_rdata_s, char_s;
    logic [3:0]  h_font_s, v_font_s;
    logic        c_valid_s, cursor_s, hsync_s, vsync_s, frame_start_s;

    vga_text_ctrl u_full (
        .pclk(pclk), .rst(rst_f), .cursor_en(cursor_en_f), .cur_col(cur_col_f),
        .cur_row(cur_row_f), .text_addr(text_addr_f), .text_rdata(text_rdata_f),
        .char(char_f), .h_font(h_font_f), .v_font(v_font_f), .c_valid(c_valid_f),
        .cursor(cursor_f), .hsync(hsync_f), .vsync(vsync_f), .frame_start(frame_start_f)
    );

    vga_text_ctrl #(
        .H_ACTIVE(14), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(7), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CHAR_W(3), .CHAR_H(2), .COLS(4), .ROWS(3), .BLINK_FRAMES(3)
    ) u_small (
        .pclk(pclk), .rst(rst_s), .cursor_en(cursor_en_s), .cur_col(cur_col_s),
        .cur_row(cur_row_s), .text_addr(text_addr_s), .text_rdata(text_rdata_s),
        .char(char_s), .h_font(h_font_s), .v_font(v_font_s), .c_valid(c_valid_s),
        .cursor(cursor_s), .hsync(hsync_s), .vsync(vsync_s), .frame_start(frame_start_s)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // packing: {addr[24:13], h_font[12:9], v_font[8:5], c_valid[4], cursor[3], hsync[2], vsync[1], frame_start[0]}
    function automatic logic [24:0] act_f();
        return {text_addr_f, h_font_f, v_font_f, c_valid_f, cursor_f, hsync_f, vsync_f, frame_start_f};
    endfunction

    function automatic logic [24:0] act_s();
        return {text_addr_s, h_font_s, v_font_s, c_valid_s, cursor_s, hsync_s, vsync_s, frame_start_s};
    endfunction

    // Closed-form expectation for cycle c after reset release.
    function automatic logic [24:0] model(input int c, input geo_t g, input int ccol,
                                          input int crow, input logic cur_on);
        int fr, tw, th, q, l, h;
        logic [11:0] a;
        logic [3:0]  hf, vf;
        logic        cv, cu, hs, vs, fs;
        fr = g.ht * g.vt;
        tw = g.cw * g.cols;
        th = g.ch * g.rows;
        q  = c % fr;
        l  = q / g.ht;
        h  = q % g.ht;
        if (l >= th) a = 12'((g.rows - 1) * g.cols + g.cols - 1);
        else         a = 12'((l / g.ch) * g.cols + ((h < tw) ? h / g.cw : g.cols - 1));
        fs = (q == 0);
        hf = 4'd0; vf = 4'd0; cv = 1'b0; cu = 1'b0;
        if (c >= 1) begin
            q  = (c - 1) % fr;
            l  = q / g.ht;
            h  = q % g.ht;
            cv = (l < th) && (h < tw);
            hf = 4'(cv ? h % g.cw : g.cw - 1);
            vf = 4'((l < th) ? l % g.ch : g.ch - 1);
            cu = cur_on && cv && (h / g.cw == ccol) && (l / g.ch == crow);
        end
        hs = 1'b1; vs = 1'b1;
        if (c >= 2) begin
            q  = (c - 2) % fr;
            l  = q / g.ht;
            h  = q % g.ht;
            hs = !((h >= g.hs_a) && (h <= g.hs_b));
            vs = !((l >= g.vs_a) && (l <= g.vs_b));
        end
        return {a, hf, vf, cv, cu, hs, vs, fs};
    endfunction

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
        cyc++;
    endtask

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    vec_t vecs[18];
    geo_t gf, gs;
    int   hits_f, bad, first_c, stray;
    int   hits_s[9];
    int   exp_hits[9] = '{6, 0, 6, 0, 0, 0, 6, 0, 0};
    logic [24:0] e, a, first_e, first_a;

    initial begin
        gf = '{800, 525, 9, 16, 70, 30, 656, 751, 490, 491};
        gs = '{21, 10, 3, 2, 4, 3, 16, 18, 8, 8};

        //          cyc    addr     hf    vf    cv    hs    vs    fs
        vecs[0]  = '{0,     12'd0,   4'd0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1,     12'd0,   4'd0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{10,    12'd1,   4'd0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{17,    12'd1,   4'd7, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{629,   12'd69,  4'd7, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{630,   12'd69,  4'd8, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{631,   12'd69,  4'd8, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{657,   12'd69,  4'd8, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{658,   12'd69,  4'd8, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{753,   12'd69,  4'd8, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{754,   12'd69,  4'd8, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{800,   12'd0,   4'd8, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{801,   12'd0,   4'd0, 4'd1,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{12800, 12'd70,  4'd8, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{12801, 12'd70,  4'd0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{13429, 12'd139, 4'd7, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{24805, 12'd70,  4'd4, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{25700, 12'd151, 4'd0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0};

        // Reset both instances; full one gets an out-of-range cursor column.
        rst_f = 1'b0; cursor_en_f = 1'b1; cur_col_f = 7'd80; cur_row_f = 5'd0; text_rdata_f = 8'h5a;
        rst_s = 1'b0; cursor_en_s = 1'b1; cur_col_s = 7'd2;  cur_row_s = 5'd1; text_rdata_s = 8'h00;
        repeat (3) @(negedge pclk);
        check("reset_state", act_f(), 25'h6);
        check("char_passthrough", {17'd0, char_f}, 25'h5a);

        rst_f = 1'b1;
        #1;
        cyc = 0;
        for (int i = 0; i < 18; i++) begin
            while (cyc < vecs[i].cyc) step();
            check($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc), act_f(),
                  {vecs[i].addr, vecs[i].hf, vecs[i].vf, vecs[i].cv, 1'b0,
                   vecs[i].hs, vecs[i].vs, vecs[i].fs});
        end

        // Mid-frame reset on line 32, held for 3 cycles.
        while (cyc < 26000) step();
        rst_f = 1'b0; cur_col_f = 7'd5; cur_row_f = 5'd2;
        step(); step(); step();
        check("mid_reset_state", act_f(), 25'h6);
        rst_f = 1'b1;
        #1;

        // After release: lines 0..33 against the closed-form model, cursor on cell (5,2).
        bad = 0; hits_f = 0; first_c = -1; first_a = '0; first_e = '0;
        for (int c = 0; c <= 27200; c++) begin
            e = model(c, gf, 5, 2, 1'b1);
            a = act_f();
            if (a !== e) begin
                if (bad == 0) begin first_c = c; first_a = a; first_e = e; end
                bad++;
            end
            if (cursor_f) hits_f++;
            if (c < 27200) step();
        end
        if (bad != 0) $display("first difference at cycle %0d: got %h want %h", first_c, first_a, first_e);
        check_int("full_restart_sweep_bad_cycles", bad, 0);
        check_int("full_cursor_cells", hits_f, 18);

        // Small geometry: 9 whole frames with per-frame cursor settings.
        rst_s = 1'b1;
        #1;
        bad = 0; stray = 0; first_c = -1; first_a = '0; first_e = '0;
        for (int f = 0; f < 9; f++) hits_s[f] = 0;
        for (int c = 0; c <= 9 * 210; c++) begin
            if ((c % 210 == 0) && (c / 210 < 9)) begin
                cursor_en_s = (c / 210 != 1);
                cur_col_s   = (c / 210 == 7) ? 7'd4 : 7'd2;
                cur_row_s   = (c / 210 == 8) ? 5'd3 : 5'd1;
            end
            e = model(c, gs, 0, 0, 1'b0);
            a = act_s() & ~25'h8;
            if (a !== e) begin
                if (bad == 0) begin first_c = c; first_a = a; first_e = e; end
                bad++;
            end
            if ((c >= 1) && cursor_s) begin
                if (model(c, gs, 2, 1, 1'b1) & 25'h8) hits_s[(c - 1) / 210]++;
                else stray++;
            end
            if (c < 9 * 210) step();
        end
        if (bad != 0) $display("first difference at cycle %0d: got %h want %h", first_c, first_a, first_e);
        check_int("small_frames_sweep_bad_cycles", bad, 0);
        for (int f = 0; f < 9; f++) check_int($sformatf("small_cursor_frame%0d", f), hits_s[f], exp_hits[f]);
        check_int("small_cursor_stray", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
